// File: rtl/uart_pkg.sv
// Shared UART definitions: frame width, the baud divider helper and the receiver state encoding.
package uart_pkg;

  localparam int unsigned DATA_BITS = 8;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } rx_state_e;

  function automatic int unsigned clks_per_bit(input int unsigned clk_hz, input int unsigned baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/uart_sync.sv
// N-flop synchronizer for an asynchronous level; resets to 1 to match an idle-high line.
module uart_sync #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic i_d,
  output logic o_q
);

  logic [STAGES-1:0] r_sync;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync <= '1;
    end else begin
      r_sync[0] <= i_d;
      for (int unsigned i = 1; i < STAGES; i++) begin
        r_sync[i] <= r_sync[i-1];
      end
    end
  end

  assign o_q = r_sync[STAGES-1];

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: mid-bit sampling, valid/ready byte output, framing-error and overrun pulses.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLK_HZ    = 50_000_000,
  parameter int unsigned BAUD_RATE = 115_200
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rxd,
  input  logic                 rx_ready,
  output logic                 rx_valid,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 frame_err,
  output logic                 overrun
);

  localparam int unsigned CLKS_PER_BIT = clks_per_bit(CLK_HZ, BAUD_RATE);
  localparam int unsigned HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int unsigned CNT_W        = $clog2(CLKS_PER_BIT);
  localparam int unsigned IDX_W        = $clog2(DATA_BITS);

  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

  generate
    if (CLKS_PER_BIT < 4) begin : g_bad_divider
      $error("uart_rx: CLK_HZ/BAUD_RATE must be at least 4");
    end
  endgenerate

  logic                 w_rxd_s;
  logic                 r_rxd_prev;
  rx_state_e            r_state;
  rx_state_e            w_state_next;
  logic [CNT_W-1:0]     r_cnt;
  logic [IDX_W-1:0]     r_idx;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_valid;
  logic [DATA_BITS-1:0] r_data;
  logic                 r_frame_err;
  logic                 r_overrun;

  logic w_cnt_clr;
  logic w_idx_clr;
  logic w_shift_en;
  logic w_byte_done;
  logic w_stop_bad;

  uart_sync #(.STAGES(2)) u_sync (
    .clk (clk),
    .rst (rst),
    .i_d (rxd),
    .o_q (w_rxd_s)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_next;
  end

  // Only a 1->0 transition starts a frame, so a line parked low never re-triggers.
  always_comb begin
    w_state_next = r_state;
    w_cnt_clr    = 1'b0;
    w_idx_clr    = 1'b0;
    w_shift_en   = 1'b0;
    w_byte_done  = 1'b0;
    w_stop_bad   = 1'b0;
    case (r_state)
      IDLE: begin
        w_cnt_clr = 1'b1;
        if (!w_rxd_s && r_rxd_prev) w_state_next = START;
      end
      START: begin
        if (r_cnt == CNT_HALF) begin
          w_cnt_clr    = 1'b1;
          w_idx_clr    = 1'b1;
          w_state_next = w_rxd_s ? IDLE : DATA;
        end
      end
      DATA: begin
        if (r_cnt == CNT_LAST) begin
          w_cnt_clr  = 1'b1;
          w_shift_en = 1'b1;
          if (r_idx == IDX_LAST) w_state_next = STOP;
        end
      end
      STOP: begin
        if (r_cnt == CNT_LAST) begin
          w_cnt_clr    = 1'b1;
          w_byte_done  = w_rxd_s;
          w_stop_bad   = !w_rxd_s;
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rxd_prev <= 1'b1;
      r_cnt      <= '0;
      r_idx      <= '0;
      r_shift    <= '0;
    end else begin
      r_rxd_prev <= w_rxd_s;
      r_cnt      <= w_cnt_clr ? '0 : r_cnt + 1'b1;
      if (w_idx_clr)       r_idx <= '0;
      else if (w_shift_en) r_idx <= r_idx + 1'b1;
      if (w_shift_en) r_shift <= {w_rxd_s, r_shift[DATA_BITS-1:1]};
    end
  end

  // A completing byte may replace the held one only if it is being consumed in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid     <= 1'b0;
      r_data      <= '0;
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_frame_err <= w_stop_bad;
      r_overrun   <= 1'b0;
      if (w_byte_done && (!r_valid || rx_ready)) begin
        r_data  <= r_shift;
        r_valid <= 1'b1;
      end else if (w_byte_done) begin
        r_overrun <= 1'b1;
      end else if (r_valid && rx_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign rx_valid  = r_valid;
  assign rx_data   = r_data;
  assign frame_err = r_frame_err;
  assign overrun   = r_overrun;

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx at 10 clocks per bit: directed frames, expected bytes queued, monitor pops on handshake.
`timescale 1ns/1ps
module tb_uart_rx;
  import uart_pkg::*;

  localparam int unsigned CLK_HZ = 1_000_000;
  localparam int unsigned BAUD   = 100_000;
  localparam int unsigned BIT_NS = 10_000;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rxd = 1'b1;
  logic       rx_ready = 1'b0;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       frame_err;
  logic       overrun;

  always #500 clk = ~clk;

  uart_rx #(.CLK_HZ(CLK_HZ), .BAUD_RATE(BAUD)) dut (
    .clk       (clk),
    .rst       (rst),
    .rxd       (rxd),
    .rx_ready  (rx_ready),
    .rx_valid  (rx_valid),
    .rx_data   (rx_data),
    .frame_err (frame_err),
    .overrun   (overrun)
  );

  int unsigned checks = 0;
  int unsigned errors = 0;
  logic [7:0]  sb[$];
  int unsigned n_valid = 0, n_fe = 0, n_ov = 0;
  int unsigned v0, f0, o0;
  logic        prev_fe = 1'b0, prev_ov = 1'b0, prev_valid = 1'b0, prev_hs = 1'b0;
  logic [7:0]  prev_data = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard on every accepted byte and polices pulse shapes.
  always @(negedge clk) begin
    if (!rst) begin
      if (rx_valid)  n_valid++;
      if (frame_err) n_fe++;
      if (overrun)   n_ov++;
      if (frame_err || overrun) check("fe_ov_exclusive", 32'(frame_err & overrun), 32'd0);
      if (frame_err) check("fe_width", 32'(prev_fe), 32'd0);
      if (overrun)   check("ov_width", 32'(prev_ov), 32'd0);
      if (prev_valid && !prev_hs) begin
        check("valid_held", 32'(rx_valid), 32'd1);
        check("data_stable", 32'(rx_data), 32'(prev_data));
      end
      if (rx_valid && rx_ready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_byte: got 0x%02h, expected none", rx_data);
        end else begin
          check("rx_data", 32'(rx_data), 32'(sb.pop_front()));
        end
      end
    end
    prev_fe    = frame_err;
    prev_ov    = overrun;
    prev_valid = rx_valid && !rst;
    prev_hs    = rx_valid && rx_ready;
    prev_data  = rx_data;
  end

  task automatic send_frame(input logic [7:0] b, input logic stop, input int unsigned bit_ns);
    logic [7:0] bits;
    bits = b;
    rxd = 1'b0;
    #(bit_ns);
    for (int i = 0; i < 8; i++) begin
      rxd = bits[i];
      #(bit_ns);
    end
    rxd = stop;
    #(bit_ns);
  endtask

  task automatic idle(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic snap();
    v0 = n_valid;
    f0 = n_fe;
    o0 = n_ov;
  endtask

  initial begin
    logic [7:0] stream [3];
    int unsigned skew [2];
    stream[0] = 8'h00; stream[1] = 8'hFF; stream[2] = 8'h55;
    skew[0] = 10_300; skew[1] = 9_700;

    repeat (3) @(negedge clk);
    check("rst_valid", 32'(rx_valid), 32'd0);
    check("rst_data", 32'(rx_data), 32'd0);
    check("rst_fe", 32'(frame_err), 32'd0);
    check("rst_ov", 32'(overrun), 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    idle(5);

    // Single byte
    rx_ready = 1'b1;
    snap();
    sb.push_back(8'h5A);
    send_frame(8'h5A, 1'b1, BIT_NS);
    idle(10);
    check("t1_valid_cycles", n_valid - v0, 32'd1);
    check("t1_fe", n_fe - f0, 32'd0);
    check("t1_ov", n_ov - o0, 32'd0);

    // Framing error, line held low, then a clean frame
    snap();
    send_frame(8'hA5, 1'b0, BIT_NS);
    idle(30);
    check("t2_fe", n_fe - f0, 32'd1);
    check("t2_no_valid", n_valid - v0, 32'd0);
    rxd = 1'b1;
    idle(15);
    sb.push_back(8'h3C);
    send_frame(8'h3C, 1'b1, BIT_NS);
    idle(10);
    check("t2_valid_after", n_valid - v0, 32'd1);
    check("t2_fe_total", n_fe - f0, 32'd1);
    check("t2_ov", n_ov - o0, 32'd0);
    check("t2_sb_empty", 32'(sb.size()), 32'd0);

    // Glitch shorter than half a bit
    snap();
    rxd = 1'b0;
    idle(3);
    rxd = 1'b1;
    idle(20);
    check("t3_valid", n_valid - v0, 32'd0);
    check("t3_fe", n_fe - f0, 32'd0);
    check("t3_ov", n_ov - o0, 32'd0);
    check("t3_state", 32'(dut.r_state), 32'(IDLE));

    // Overrun with consumer stalled
    rx_ready = 1'b0;
    snap();
    sb.push_back(8'h11);
    send_frame(8'h11, 1'b1, BIT_NS);
    send_frame(8'h22, 1'b1, BIT_NS);
    idle(10);
    check("t4a_ov", n_ov - o0, 32'd1);
    check("t4a_fe", n_fe - f0, 32'd0);
    @(negedge clk);
    check("t4a_valid", 32'(rx_valid), 32'd1);
    check("t4a_data", 32'(rx_data), 32'h11);

    // Consume the held byte in exactly the cycle the next one completes
    idle(5);
    snap();
    sb.push_back(8'h33);
    fork
      send_frame(8'h33, 1'b1, BIT_NS);
      begin
        repeat (97) @(posedge clk);
        #1 rx_ready = 1'b1;
        @(posedge clk);
        #1 rx_ready = 1'b0;
        @(negedge clk);
        check("t4b_valid", 32'(rx_valid), 32'd1);
        check("t4b_data", 32'(rx_data), 32'h33);
        check("t4b_sb_depth", 32'(sb.size()), 32'd1);
      end
    join
    idle(5);
    check("t4b_ov", n_ov - o0, 32'd0);
    rx_ready = 1'b1;
    idle(3);
    @(negedge clk);
    check("t4b_drained", 32'(rx_valid), 32'd0);
    check("t4b_sb_empty", 32'(sb.size()), 32'd0);

    // Reset in the middle of the data bits
    snap();
    fork
      send_frame(8'hFF, 1'b1, BIT_NS);
      begin
        repeat (53) @(posedge clk);
        #1 rst = 1'b1;
        repeat (2) @(negedge clk);
        check("t5_valid_in_rst", 32'(rx_valid), 32'd0);
        check("t5_data_in_rst", 32'(rx_data), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
      end
    join
    idle(10);
    sb.push_back(8'h81);
    send_frame(8'h81, 1'b1, BIT_NS);
    idle(10);
    check("t5_valid", n_valid - v0, 32'd1);
    check("t5_fe", n_fe - f0, 32'd0);
    check("t5_ov", n_ov - o0, 32'd0);
    check("t5_sb_empty", 32'(sb.size()), 32'd0);

    // Back-to-back streams at +3% and -3% bit period
    snap();
    for (int s = 0; s < 2; s++) begin
      for (int k = 0; k < 3; k++) begin
        sb.push_back(stream[k]);
        send_frame(stream[k], 1'b1, skew[s]);
      end
      idle(15);
    end
    check("t6_valid", n_valid - v0, 32'd6);
    check("t6_fe", n_fe - f0, 32'd0);
    check("t6_ov", n_ov - o0, 32'd0);
    check("t6_sb_empty", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #20_000_000;
    $display("FAIL watchdog: simulation exceeded 20000 clocks, expected completion");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "watchdog expired");
  end

endmodule
